// File: rtl/axi2apb_slave_regs_pkg.sv
// Shared definitions for the APB control-register completer.
// Holds the FSM encoding, the offsets of the read-only registers relative to
// NUM_REGS, and the width helper for the optional wait-state counter.
package axi2apb_slave_regs_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Read-only registers sit directly above the RW bank.
    localparam int IDX_STATUS_OFS = 0;
    localparam int IDX_XFER_OFS   = 1;

    // Counter width able to hold WAIT_CYCLES; never narrower than one bit.
    function automatic int wcnt_bits(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/axi2apb_slave_regs_if.sv
// APB completer-side signal bundle (one pselSX/preadySX/pslverrSX/prdataSX port).
// master: drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr.
// slave:  the mirror image, used by axi2apb_slave_regs.
interface axi2apb_slave_regs_if #(
    parameter int ADDR_BITS = 8
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_BITS-1:0] paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/axi2apb_slave_regs_wait_cnt.sv
// Wait-state counter: loads WAIT_CYCLES at setup, counts down while selected.
// Latency: zero flag is registered state, valid the cycle after the load.
// Backpressure: none; the owner holds pready low until zero is set.
// Only built when AXI2APB_SLV_WAIT_EN is defined.
`ifdef AXI2APB_SLV_WAIT_EN
module axi2apb_slave_regs_wait_cnt #(
    parameter int WAIT_CYCLES = 2,
    parameter int WCNT_BITS   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [WCNT_BITS-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= WCNT_BITS'(WAIT_CYCLES);
        end else if (dec && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign zero = (wait_cnt == '0);
endmodule
`endif

// File: rtl/axi2apb_slave_regs.sv
// APB completer with NUM_REGS RW registers plus RO status and transfer-count registers.
// Latency: setup->done is 2 clk, plus WAIT_CYCLES when AXI2APB_SLV_WAIT_EN is defined.
// Backpressure: pready held low during wait states; pslverr flags unmapped/RO-write.
// Ports: clk, reset (async, active-high), apb (slave modport), status_in (RO status
// value sampled at completion), regs_q (flat RW contents, reg i at [32*i+31:32*i]).
module axi2apb_slave_regs
    import axi2apb_slave_regs_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    axi2apb_slave_regs_if.slave      apb,
    input  logic [31:0]              status_in,
    output logic [NUM_REGS*32-1:0]   regs_q
);
    localparam int IDX_BITS = ADDR_BITS - 2;
    localparam logic [IDX_BITS-1:0] IDX_STATUS = IDX_BITS'(NUM_REGS + IDX_STATUS_OFS);
    localparam logic [IDX_BITS-1:0] IDX_XFER   = IDX_BITS'(NUM_REGS + IDX_XFER_OFS);

    state_t              state;
    logic [IDX_BITS-1:0] idx_q;
    logic                dir_q;      // latched pwrite
    logic [31:0]         wdata_q;
    logic [31:0]         xfer_cnt;
    logic                wait_done;
    logic                setup_vld;
    logic [31:0]         rd_dat;
    logic                is_rw, is_ro, is_err;
    logic [1:0]          paddr_lsb_unused;

    assign paddr_lsb_unused = apb.paddr[1:0];

    // A setup phase is only honoured from IDLE; psel&penable there is ignored.
    assign setup_vld = (state == ST_IDLE) && apb.psel && !apb.penable;

`ifdef AXI2APB_SLV_WAIT_EN
    axi2apb_slave_regs_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .WCNT_BITS   (wcnt_bits(WAIT_CYCLES))
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (setup_vld),
        .dec   ((state == ST_ACCESS) && apb.psel),
        .zero  (wait_done)
    );
`else
    localparam int wait_cycles_unused = WAIT_CYCLES;
    assign wait_done = 1'b1;
`endif

    assign apb.pready = (state == ST_ACCESS) && apb.psel && apb.penable && wait_done;

    // Decode on the index latched at setup.
    assign is_rw  = (idx_q < IDX_BITS'(NUM_REGS));
    assign is_ro  = (idx_q == IDX_STATUS) || (idx_q == IDX_XFER);
    assign is_err = !(is_rw || is_ro) || (dir_q && is_ro);

    assign apb.pslverr = apb.pready && is_err;

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_BITS'(i)) rd_dat = regs_q[32*i +: 32];
        end
        if (idx_q == IDX_STATUS) rd_dat = status_in;
        if (idx_q == IDX_XFER)   rd_dat = xfer_cnt;   // pre-increment value
    end

    assign apb.prdata = (apb.pready && !dir_q && !is_err) ? rd_dat : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            wdata_q  <= '0;
            xfer_cnt <= '0;
            regs_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup_vld) begin
                        state   <= ST_ACCESS;
                        idx_q   <= apb.paddr[ADDR_BITS-1:2];
                        dir_q   <= apb.pwrite;
                        wdata_q <= apb.pwdata;
                    end
                end
                ST_ACCESS: begin
                    if (!apb.psel) begin
                        // Aborted transfer: nothing commits, nothing is counted.
                        state <= ST_IDLE;
                    end else if (apb.pready) begin
                        state    <= ST_IDLE;
                        xfer_cnt <= xfer_cnt + 32'd1;
                        if (dir_q && is_rw) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (idx_q == IDX_BITS'(i)) regs_q[32*i +: 32] <= wdata_q;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
